// File: rtl/vga_timing_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_timing_gen_pkg : shared raster timing defaults, widths, phase encoding |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package vga_timing_gen_pkg;

    localparam int c_def_h_active = 640;
    localparam int c_def_h_front  = 16;
    localparam int c_def_h_sync   = 96;
    localparam int c_def_h_back   = 48;
    localparam int c_def_v_active = 480;
    localparam int c_def_v_front  = 10;
    localparam int c_def_v_sync   = 2;
    localparam int c_def_v_back   = 33;

    localparam int c_x_w  = 10;
    localparam int c_y_w  = 10;
    localparam int c_fc_w = 12;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_timing_gen_if : pixel-rate enable in, raster timing outputs out        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface vga_timing_gen_if;
    import vga_timing_gen_pkg::*;

    logic                enable;
    logic [c_x_w-1:0]    x;
    logic [c_y_w-1:0]    y;
    logic                active;
    logic                hsync;
    logic                vsync;
    logic                line_start;
    logic                frame_start;
    logic [c_fc_w-1:0]   frame_count;
    logic                hsync_d;
    logic                vsync_d;
    logic                active_d;

    modport master (
        input  enable,
        output x, y, active, hsync, vsync, line_start, frame_start,
               frame_count, hsync_d, vsync_d, active_d
    );

    modport slave (
        output enable,
        input  x, y, active, hsync, vsync, line_start, frame_start,
               frame_count, hsync_d, vsync_d, active_d
    );

endinterface
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_axis_counter : one raster axis - position counter, phase FSM, sync     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module vga_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int   WIDTH    = 10,
    parameter int   ACTIVE   = 640,
    parameter int   FRONT    = 16,
    parameter int   SYNC     = 96,
    parameter int   BACK     = 48,
    parameter logic SYNC_POL = 1'b0
) (
    input  wire logic             clock,
    input  wire logic             reset_n,
    input  wire logic             i_inc,
    output logic [WIDTH-1:0]      o_count,
    output logic                  o_wrap,
    output logic                  o_act_next,
    output logic                  o_sync
);

    localparam int               c_total    = ACTIVE + FRONT + SYNC + BACK;
    localparam logic [WIDTH-1:0] c_front_at = WIDTH'(ACTIVE);
    localparam logic [WIDTH-1:0] c_sync_at  = WIDTH'(ACTIVE + FRONT);
    localparam logic [WIDTH-1:0] c_back_at  = WIDTH'(ACTIVE + FRONT + SYNC);
    localparam logic [WIDTH-1:0] c_last     = WIDTH'(c_total - 1);

    phase_t           r_phase;
    phase_t           w_phase_next;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic             r_sync;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_phase <= PH_ACTIVE;
            r_sync  <= ~SYNC_POL;
        end else if (i_inc) begin
            r_count <= w_count_next;
            r_phase <= w_phase_next;
            r_sync  <= (w_phase_next == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        end
    end

    // Phase decisions look at the next count so phase and sync land on the same edge as the count.
    always_comb begin
        w_count_next = r_count;
        w_phase_next = r_phase;
        if (i_inc) begin
            w_count_next = (r_count == c_last) ? '0 : r_count + 1'b1;
        end
        case (r_phase)
            PH_ACTIVE: if (w_count_next == c_front_at) w_phase_next = PH_FRONT;
            PH_FRONT:  if (w_count_next == c_sync_at)  w_phase_next = PH_SYNC;
            PH_SYNC:   if (w_count_next == c_back_at)  w_phase_next = PH_BACK;
            PH_BACK:   if (w_count_next == '0)         w_phase_next = PH_ACTIVE;
            default:                                   w_phase_next = PH_ACTIVE;
        endcase
    end

    assign o_count    = r_count;
    assign o_wrap     = i_inc && (r_count == c_last);
    assign o_act_next = (w_phase_next == PH_ACTIVE);
    assign o_sync     = r_sync;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_timing_gen : raster timing source with strobes, frame count and        |
// |                  pipeline-matched delayed sync/active. Rev 1.0             |
// +----------------------------------------------------------------------------+
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int   H_ACTIVE = c_def_h_active,
    parameter int   H_FRONT  = c_def_h_front,
    parameter int   H_SYNC   = c_def_h_sync,
    parameter int   H_BACK   = c_def_h_back,
    parameter int   V_ACTIVE = c_def_v_active,
    parameter int   V_FRONT  = c_def_v_front,
    parameter int   V_SYNC   = c_def_v_sync,
    parameter int   V_BACK   = c_def_v_back,
    parameter logic SYNC_POL = 1'b0,
    parameter int   DELAY    = 2
) (
    input  wire logic        clock,
    input  wire logic        reset_n,
    vga_timing_gen_if.master bus
);

    localparam logic [2:0] c_taps_idle = {~SYNC_POL, ~SYNC_POL, 1'b0};

    logic [c_x_w-1:0]  w_x;
    logic [c_y_w-1:0]  w_y;
    logic              w_h_wrap;
    logic              w_v_wrap;
    logic              w_h_act_next;
    logic              w_v_act_next;
    logic              w_hsync;
    logic              w_vsync;
    logic              r_active;
    logic              r_line_start;
    logic              r_frame_start;
    logic [c_fc_w-1:0] r_frame_count;
    logic [2:0]        w_taps_in;
    logic [2:0]        w_taps_out;

    vga_axis_counter #(
        .WIDTH    (c_x_w),
        .ACTIVE   (H_ACTIVE),
        .FRONT    (H_FRONT),
        .SYNC     (H_SYNC),
        .BACK     (H_BACK),
        .SYNC_POL (SYNC_POL)
    ) u_h (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_inc      (bus.enable),
        .o_count    (w_x),
        .o_wrap     (w_h_wrap),
        .o_act_next (w_h_act_next),
        .o_sync     (w_hsync)
    );

    vga_axis_counter #(
        .WIDTH    (c_y_w),
        .ACTIVE   (V_ACTIVE),
        .FRONT    (V_FRONT),
        .SYNC     (V_SYNC),
        .BACK     (V_BACK),
        .SYNC_POL (SYNC_POL)
    ) u_v (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_inc      (w_h_wrap),
        .o_count    (w_y),
        .o_wrap     (w_v_wrap),
        .o_act_next (w_v_act_next),
        .o_sync     (w_vsync)
    );

    // Wrap flags already include enable, so strobes drop to 0 in any idle cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_active      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
            if (w_v_wrap) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
            if (bus.enable) begin
                r_active <= w_h_act_next & w_v_act_next;
            end
        end
    end

    assign w_taps_in = {w_hsync, w_vsync, r_active};

    generate
        if (DELAY == 0) begin : g_pass
            assign w_taps_out = w_taps_in;
        end else begin : g_pipe
            logic [2:0] r_pipe [DELAY];

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DELAY; i++) begin
                        r_pipe[i] <= c_taps_idle;
                    end
                end else if (bus.enable) begin
                    r_pipe[0] <= w_taps_in;
                    for (int i = 1; i < DELAY; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_taps_out = r_pipe[DELAY-1];
        end
    endgenerate

    assign bus.x           = w_x;
    assign bus.y           = w_y;
    assign bus.active      = r_active;
    assign bus.hsync       = w_hsync;
    assign bus.vsync       = w_vsync;
    assign bus.line_start  = r_line_start;
    assign bus.frame_start = r_frame_start;
    assign bus.frame_count = r_frame_count;
    assign bus.hsync_d     = w_taps_out[2];
    assign bus.vsync_d     = w_taps_out[1];
    assign bus.active_d    = w_taps_out[0];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_timing_gen : randomized scoreboard bench against a raster model     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_vga_timing_gen;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        bit pol;
        int dly;
    } tcfg_t;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        active;
        logic        hsync;
        logic        vsync;
        logic        ls;
        logic        fs;
        logic [11:0] fc;
        logic        hd;
        logic        vd;
        logic        ad;
    } exp_t;

    localparam tcfg_t CA = '{ha:16, hf:2, hs:3, hb:3, va:10, vf:2, vs:2, vb:3, pol:1'b0, dly:2};
    localparam tcfg_t CB = '{ha:1, hf:1, hs:1, hb:1, va:1, vf:1, vs:1, vb:1, pol:1'b1, dly:0};
    localparam int    NCYC = 66000;

    logic clock;
    logic rst_a_n;
    logic rst_b_n;
    int   checks;
    int   errors;
    exp_t qa[$];
    exp_t qb[$];

    vga_timing_gen_if ifa();
    vga_timing_gen_if ifb();

    vga_timing_gen #(
        .H_ACTIVE(CA.ha), .H_FRONT(CA.hf), .H_SYNC(CA.hs), .H_BACK(CA.hb),
        .V_ACTIVE(CA.va), .V_FRONT(CA.vf), .V_SYNC(CA.vs), .V_BACK(CA.vb),
        .SYNC_POL(CA.pol), .DELAY(CA.dly)
    ) dut_a (
        .clock   (clock),
        .reset_n (rst_a_n),
        .bus     (ifa)
    );

    vga_timing_gen #(
        .H_ACTIVE(CB.ha), .H_FRONT(CB.hf), .H_SYNC(CB.hs), .H_BACK(CB.hb),
        .V_ACTIVE(CB.va), .V_FRONT(CB.vf), .V_SYNC(CB.vs), .V_BACK(CB.vb),
        .SYNC_POL(CB.pol), .DELAY(CB.dly)
    ) dut_b (
        .clock   (clock),
        .reset_n (rst_b_n),
        .bus     (ifb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Raster position is just the number of enabled cycles since reset.
    function automatic exp_t base(tcfg_t c, longint n);
        exp_t   e;
        longint ht;
        longint vt;
        longint xx;
        longint yy;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        xx = n % ht;
        yy = (n / ht) % vt;
        e = '0;
        e.x      = 10'(xx);
        e.y      = 10'(yy);
        e.fc     = 12'((n / (ht * vt)) % 4096);
        e.active = (n > 0) && (xx < c.ha) && (yy < c.va);
        e.hsync  = (xx >= c.ha + c.hf && xx < c.ha + c.hf + c.hs) ? c.pol : ~c.pol;
        e.vsync  = (yy >= c.va + c.vf && yy < c.va + c.vf + c.vs) ? c.pol : ~c.pol;
        return e;
    endfunction

    function automatic exp_t model(tcfg_t c, longint n, bit stepped);
        exp_t e;
        exp_t d;
        e    = base(c, n);
        e.ls = stepped && (e.x == 10'd0);
        e.fs = stepped && (e.x == 10'd0) && (e.y == 10'd0);
        if (n >= c.dly) begin
            d    = base(c, n - c.dly);
            e.hd = d.hsync;
            e.vd = d.vsync;
            e.ad = d.active;
        end else begin
            e.hd = ~c.pol;
            e.vd = ~c.pol;
            e.ad = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input exp_t a, input exp_t e);
        chk({tag, ".x"},           12'(a.x),  12'(e.x));
        chk({tag, ".y"},           12'(a.y),  12'(e.y));
        chk({tag, ".active"},      12'(a.active), 12'(e.active));
        chk({tag, ".hsync"},       12'(a.hsync),  12'(e.hsync));
        chk({tag, ".vsync"},       12'(a.vsync),  12'(e.vsync));
        chk({tag, ".line_start"},  12'(a.ls), 12'(e.ls));
        chk({tag, ".frame_start"}, 12'(a.fs), 12'(e.fs));
        chk({tag, ".frame_count"}, a.fc, e.fc);
        chk({tag, ".hsync_d"},     12'(a.hd), 12'(e.hd));
        chk({tag, ".vsync_d"},     12'(a.vd), 12'(e.vd));
        chk({tag, ".active_d"},    12'(a.ad), 12'(e.ad));
    endtask

    // Monitor: every clock the DUTs present a full output set; pop and compare.
    initial begin
        exp_t ea;
        exp_t aa;
        forever begin
            @(posedge clock);
            #1;
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                aa = {ifa.x, ifa.y, ifa.active, ifa.hsync, ifa.vsync, ifa.line_start,
                      ifa.frame_start, ifa.frame_count, ifa.hsync_d, ifa.vsync_d, ifa.active_d};
                cmp("A", aa, ea);
            end
            if (qb.size() > 0) begin
                ea = qb.pop_front();
                aa = {ifb.x, ifb.y, ifb.active, ifb.hsync, ifb.vsync, ifb.line_start,
                      ifb.frame_start, ifb.frame_count, ifb.hsync_d, ifb.vsync_d, ifb.active_d};
                cmp("B", aa, ea);
            end
        end
    end

    // Stimulus: A gets random enables and sporadic mid-frame resets, B runs long enough
    // for frame_count to pass 4095; both start with an enable toggling 1/0 stretch.
    initial begin
        longint na;
        longint nb;
        int     hold;
        bit     ra;
        bit     ea;
        bit     rb;
        bit     eb;
        checks     = 0;
        errors     = 0;
        na         = 0;
        nb         = 0;
        hold       = 0;
        rst_a_n    = 1'b0;
        rst_b_n    = 1'b0;
        ifa.enable = 1'b0;
        ifb.enable = 1'b0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clock);
            if (cyc < 4) begin
                ra = 1'b0;
            end else if (hold > 0) begin
                ra = 1'b0;
                hold--;
            end else if ($urandom_range(0, 2999) == 0) begin
                ra   = 1'b0;
                hold = $urandom_range(0, 2);
            end else begin
                ra = 1'b1;
            end
            ea = (cyc < 200) ? cyc[0] : ($urandom_range(0, 3) != 0);
            rb = (cyc >= 4);
            eb = (cyc < 200) ? cyc[0] : 1'b1;

            rst_a_n    = ra;
            ifa.enable = ea;
            rst_b_n    = rb;
            ifb.enable = eb;

            if (!ra) begin
                na = 0;
                qa.push_back(model(CA, na, 1'b0));
            end else begin
                if (ea) na++;
                qa.push_back(model(CA, na, ea));
            end
            if (!rb) begin
                nb = 0;
                qb.push_back(model(CB, nb, 1'b0));
            end else begin
                if (eb) nb++;
                qb.push_back(model(CB, nb, eb));
            end
        end
        @(posedge clock);
        #2;
        chk("A.queue_left", 12'(qa.size()), 12'd0);
        chk("B.queue_left", 12'(qb.size()), 12'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
